// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller.
// Allocates up to four indices per cycle, marks entries done from the forwarding
// bus, retires up to two per cycle in order, and squashes younger entries on flush.
module rob_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       disp_valid,
  output logic             disp_ready,
  output logic [IDX_W-1:0] disp_idx_a,
  output logic [IDX_W-1:0] disp_idx_b,
  output logic [IDX_W-1:0] disp_idx_c,
  output logic [IDX_W-1:0] disp_idx_d,
  input  logic [22:0]      fwd_a,
  input  logic [22:0]      fwd_b,
  input  logic [22:0]      fwd_c,
  input  logic [22:0]      fwd_d,
  input  logic             commit_en,
  output logic [1:0]       commit_valid,
  output logic [IDX_W-1:0] commit_idx0,
  output logic [IDX_W-1:0] commit_idx1,
  input  logic             flush_valid,
  input  logic [IDX_W-1:0] flush_idx,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d;

  logic [22:0]      fwd [4];
  logic [IDX_W-1:0] head1;
  logic [CNT_W-1:0] free_cnt;
  logic [2:0]       ndisp_raw, ndisp;
  logic [1:0]       ncommit;
  logic [CNT_W-1:0] nsquash;
  logic             disp_fire;

  assign fwd[0] = fwd_a;
  assign fwd[1] = fwd_b;
  assign fwd[2] = fwd_c;
  assign fwd[3] = fwd_d;

  assign head1    = head_q + IDX_W'(1);
  assign free_cnt = CNT_W'(DEPTH) - count_q;

  assign disp_ready = free_cnt >= CNT_W'(4);
  assign disp_idx_a = tail_q;
  assign disp_idx_b = tail_q + IDX_W'(1);
  assign disp_idx_c = tail_q + IDX_W'(2);
  assign disp_idx_d = tail_q + IDX_W'(3);
  assign commit_idx0 = head_q;
  assign commit_idx1 = head1;
  assign count = count_q;
  assign empty = count_q == '0;
  assign full  = count_q == CNT_W'(DEPTH);

  // In-order retirement; slot1 only follows a retiring slot0.
  assign commit_valid[1] = commit_en & alloc_q[head_q] & done_q[head_q];
  assign commit_valid[0] = commit_valid[1] & alloc_q[head1] & done_q[head1];
  assign ncommit = {1'b0, commit_valid[1]} + {1'b0, commit_valid[0]};

  // Leading-ones count of the lane request; illegal patterns collapse to their prefix.
  always_comb begin
    ndisp_raw = 3'd0;
    casez (disp_valid)
      4'b0???: ndisp_raw = 3'd0;
      4'b10??: ndisp_raw = 3'd1;
      4'b110?: ndisp_raw = 3'd2;
      4'b1110: ndisp_raw = 3'd3;
      4'b1111: ndisp_raw = 3'd4;
      default: ndisp_raw = 3'd0;
    endcase
  end

  assign disp_fire = disp_ready & ~flush_valid & (ndisp_raw != 3'd0);
  assign ndisp     = disp_fire ? ndisp_raw : 3'd0;
  assign nsquash   = flush_valid ? CNT_W'(tail_q - flush_idx - IDX_W'(1)) : '0;

  // Next-state for pointers, occupancy and per-entry status bits.
  always_comb begin
    logic [IDX_W-1:0] sq_off, dp_off, fidx;
    logic             sq, dp, cm;
    alloc_d = alloc_q;
    done_d  = done_q;
    head_d  = head_q + IDX_W'(ncommit);
    tail_d  = flush_valid ? flush_idx + IDX_W'(1) : tail_q + IDX_W'(ndisp);
    count_d = count_q + CNT_W'(ndisp) - CNT_W'(ncommit) - nsquash;
    // Completions only land on entries already allocated before this edge.
    for (int s = 0; s < 4; s++) begin
      fidx = fwd[s][16 +: IDX_W];
      if (fwd[s][22] && alloc_q[fidx]) done_d[fidx] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      sq_off = IDX_W'(i) - flush_idx - IDX_W'(1);
      dp_off = IDX_W'(i) - tail_q;
      sq = flush_valid && (CNT_W'(sq_off) < nsquash);
      dp = CNT_W'(dp_off) < CNT_W'(ndisp);
      cm = (commit_valid[1] && (IDX_W'(i) == head_q)) ||
           (commit_valid[0] && (IDX_W'(i) == head1));
      if (sq || cm) begin
        alloc_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
      if (dp) begin
        alloc_d[i] = 1'b1;
        done_d[i]  = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

`ifndef SYNTHESIS
  // A flush must name a live entry.
  flush_idx_alloc: assert property (@(posedge clk) disable iff (!rst_n)
    flush_valid |-> alloc_q[flush_idx]);
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: commit scoreboard plus direct pointer/count checks.
module tb_rob_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_idx_a, disp_idx_b, disp_idx_c, disp_idx_d;
  logic [22:0] fwd_a, fwd_b, fwd_c, fwd_d;
  logic        commit_en;
  logic [1:0]  commit_valid;
  logic [5:0]  commit_idx0, commit_idx1;
  logic        flush_valid;
  logic [5:0]  flush_idx;
  logic [6:0]  count;
  logic        empty, full;

  typedef struct packed {
    logic [1:0] cv;
    logic [5:0] i0;
    logic [5:0] i1;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  rob_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_idx_a(disp_idx_a), .disp_idx_b(disp_idx_b),
    .disp_idx_c(disp_idx_c), .disp_idx_d(disp_idx_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .commit_en(commit_en), .commit_valid(commit_valid),
    .commit_idx0(commit_idx0), .commit_idx1(commit_idx1),
    .flush_valid(flush_valid), .flush_idx(flush_idx),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [22:0] slot(input logic [5:0] idx);
    return {1'b1, idx, 16'hBEEF};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    fwd_a = '0; fwd_b = '0; fwd_c = '0; fwd_d = '0;
  endtask

  task automatic push(input logic [1:0] cv, input logic [5:0] i0, input logic [5:0] i1);
    exp_t e;
    e.cv = cv; e.i0 = i0; e.i1 = i1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    disp_valid = '0; flush_valid = 1'b0; flush_idx = '0; commit_en = 1'b1;
    clr_fwd();
    step();
    rst_n = 1'b1;
  endtask

  // Commit monitor: every presented retirement must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && commit_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got cv=%0d idx0=%0d, expected none",
                 commit_valid, commit_idx0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_valid", 32'(commit_valid), 32'(e.cv));
        chk("commit_idx0", 32'(commit_idx0), 32'(e.i0));
        chk("commit_idx1", 32'(commit_idx1), 32'(e.i1));
      end
    end
  end

  initial begin
    do_reset();
    // Reset values
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_idx_a", 32'(disp_idx_a), 0);
    chk("rst_idx_d", 32'(disp_idx_d), 3);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_cidx1", 32'(commit_idx1), 1);

    // Fill the ROB with 16 four-wide dispatches
    for (int k = 0; k < 16; k++) begin
      chk("fill_idx_a", 32'(disp_idx_a), 32'(4 * k));
      disp_valid = 4'b1111;
      step();
    end
    chk("fill_count", 32'(count), 64);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(disp_ready), 0);
    step();  // 17th request must be dropped
    disp_valid = '0;
    chk("drop_count", 32'(count), 64);
    chk("drop_tail", 32'(disp_idx_a), 0);

    // Complete 0 and 1 on a full ROB
    fwd_a = slot(6'd0); fwd_b = slot(6'd1);
    push(2'b11, 6'd0, 6'd1);
    step();
    clr_fwd();
    chk("full_cmt_ready", 32'(disp_ready), 0);
    step();
    chk("cmt_head", 32'(commit_idx0), 2);
    chk("cmt_count62", 32'(count), 62);
    chk("ready_at62", 32'(disp_ready), 0);
    fwd_c = slot(6'd2); fwd_d = slot(6'd3);
    push(2'b11, 6'd2, 6'd3);
    step();
    clr_fwd();
    step();
    chk("count60", 32'(count), 60);
    chk("ready_at60", 32'(disp_ready), 1);

    // In-order retirement and commit_en stall
    do_reset();
    disp_valid = 4'b1111;
    step();
    disp_valid = '0;
    fwd_c = slot(6'd1);
    step();
    clr_fwd();
    chk("ooo_no_commit", 32'(commit_valid), 0);
    fwd_a = slot(6'd0);
    commit_en = 1'b0;
    step();
    clr_fwd();
    chk("stall_cv", 32'(commit_valid), 0);
    step();
    chk("stall_head", 32'(commit_idx0), 0);
    chk("stall_count", 32'(count), 4);
    push(2'b11, 6'd0, 6'd1);
    commit_en = 1'b1;
    step();
    chk("inorder_head", 32'(commit_idx0), 2);
    chk("inorder_count", 32'(count), 2);
    fwd_a = slot(6'd2); fwd_d = slot(6'd2); fwd_b = slot(6'd3);  // duplicate slot
    push(2'b11, 6'd2, 6'd3);
    step();
    clr_fwd();
    step();
    chk("dup_empty", 32'(empty), 1);

    // Walk the pointers from 4 up to 60
    for (int k = 0; k < 14; k++) begin
      logic [5:0] t;
      t = 6'(4 + 4 * k);
      disp_valid = 4'b1111;
      step();
      disp_valid = '0;
      fwd_a = slot(t); fwd_b = slot(t + 6'd1); fwd_c = slot(t + 6'd2); fwd_d = slot(t + 6'd3);
      push(2'b11, t, t + 6'd1);
      push(2'b11, t + 6'd2, t + 6'd3);
      step();
      clr_fwd();
      step();
      step();
    end
    chk("walk_head", 32'(commit_idx0), 60);
    disp_valid = 4'b1011;  // illegal: treated as one lane
    step();
    chk("illegal_count", 32'(count), 1);
    chk("illegal_tail", 32'(disp_idx_a), 61);
    disp_valid = 4'b1000;
    step();
    disp_valid = '0;
    fwd_b = slot(6'd60);
    push(2'b10, 6'd60, 6'd61);
    step();
    clr_fwd();
    step();
    fwd_a = slot(6'd61);
    push(2'b10, 6'd61, 6'd62);
    step();
    clr_fwd();
    step();
    chk("pre_wrap_head", 32'(commit_idx0), 62);
    chk("pre_wrap_empty", 32'(empty), 1);

    // Wrap-around dispatch and retirement
    chk("wrap_idx_a", 32'(disp_idx_a), 62);
    chk("wrap_idx_b", 32'(disp_idx_b), 63);
    chk("wrap_idx_c", 32'(disp_idx_c), 0);
    chk("wrap_idx_d", 32'(disp_idx_d), 1);
    disp_valid = 4'b1111;
    step();
    disp_valid = '0;
    chk("wrap_tail", 32'(disp_idx_a), 2);
    chk("wrap_count", 32'(count), 4);
    fwd_a = slot(6'd62); fwd_b = slot(6'd63); fwd_c = slot(6'd0); fwd_d = slot(6'd1);
    push(2'b11, 6'd62, 6'd63);
    push(2'b11, 6'd0, 6'd1);
    step();
    clr_fwd();
    step();
    step();
    chk("wrap_head", 32'(commit_idx0), 2);
    chk("wrap_empty", 32'(empty), 1);

    // Flush wins over dispatch
    do_reset();
    disp_valid = 4'b1111;
    step();
    step();
    disp_valid = 4'b1100;
    step();
    chk("preflush_count", 32'(count), 10);
    disp_valid = 4'b1111;
    flush_valid = 1'b1; flush_idx = 6'd3;
    step();
    disp_valid = '0; flush_valid = 1'b0;
    chk("flush_count", 32'(count), 4);
    chk("flush_tail", 32'(disp_idx_a), 4);
    fwd_a = slot(6'd7);
    step();
    clr_fwd();
    step();
    chk("squashed_cmp_cv", 32'(commit_valid), 0);
    chk("squashed_cmp_count", 32'(count), 4);
    fwd_a = slot(6'd0); fwd_b = slot(6'd1); fwd_c = slot(6'd2); fwd_d = slot(6'd3);
    push(2'b11, 6'd0, 6'd1);
    push(2'b11, 6'd2, 6'd3);
    step();
    clr_fwd();
    step();
    step();
    chk("postflush_empty", 32'(empty), 1);
    chk("postflush_head", 32'(commit_idx0), 4);

    // Asynchronous reset with retirement pending
    for (int k = 0; k < 5; k++) begin
      disp_valid = 4'b1111;
      step();
    end
    disp_valid = '0;
    chk("prereset_count", 32'(count), 20);
    fwd_a = slot(6'd4); fwd_b = slot(6'd5);
    step();
    clr_fwd();
    chk("prereset_cv", 32'(commit_valid), 3);
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_cv", 32'(commit_valid), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_idx_a", 32'(disp_idx_a), 0);
    chk("async_cidx0", 32'(commit_idx0), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("after_reset_count", 32'(count), 0);

    repeat (3) step();
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Pointer and status controller for the 64-entry reorder buffer of the 4-wide out-of-order core.
- Allocates ROB indices to up to four decoded instructions per cycle (lanes A-D), in program order.
- Marks entries done from the four forwarding-bus slots.
- Retires up to two done entries per cycle in order, matching the two register-file write ports.
- Squashes younger entries on a branch flush.
- Holds no payload; the ROB data array is indexed by this block's outputs.

Parameters:
- DEPTH, 64, number of ROB entries; must be a power of two.
- IDX_W, 6, log2(DEPTH); the index width on every port.
- CNT_W, 7, occupancy counter width (IDX_W+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  4  lane request, bit3=A .. bit0=D. Legal patterns: 0000, 1000, 1100, 1110, 1111.
- disp_ready  out  1  high when at least 4 entries are free.
- disp_idx_a/b/c/d  out  IDX_W each  indices tail, tail+1, tail+2, tail+3 (mod DEPTH).
- fwd_a/b/c/d  in  23 each  forwarding slots: [22] valid, [21:16] ROB index, [15:0] value (value ignored here).
- commit_en  in  1  retire enable; low stalls retirement.
- commit_valid  out  2  bit1=slot0 (oldest), bit0=slot1.
- commit_idx0/commit_idx1  out  IDX_W each  head, head+1.
- flush_valid  in  1  squash request.
- flush_idx  in  IDX_W  index of the mispredicted instruction. It survives; all younger entries are squashed.
- count  out  CNT_W  occupancy, 0..64.
- empty/full  out  1 each  count==0 / count==64.

Behaviour:
- State:
  - head, tail: IDX_W each.
  - count: CNT_W.
  - alloc[DEPTH] and done[DEPTH] status bits.
- Reset (async, rst_n=0):
  - head=tail=0, count=0, all alloc/done cleared.
  - Outputs: disp_ready=1, disp_idx_a..d=0..3, commit_valid=00, commit_idx0=0, commit_idx1=1, count=0, empty=1, full=0.
  - A reset asserted mid-operation discards all entries immediately; no partial commit occurs.
- Outputs are combinational from registered state only. No input-to-output paths.
- Dispatch:
  - Accepted when disp_ready=1, flush_valid=0 and disp_valid!=0.
  - ndisp = number of leading ones in disp_valid. An illegal pattern such as 1011 is treated as its leading-ones prefix (1000).
  - At the edge, the ndisp entries from tail get alloc=1 and done=0; tail += ndisp (mod DEPTH).
  - When disp_ready=0, requests are dropped; the requester holds them.
- Completion:
  - For each fwd slot with valid=1 and alloc[idx]=1, set done[idx] at the edge.
  - Ignored when the index is unallocated, including an entry being allocated in the same cycle.
  - Duplicate indices across slots are harmless.
- Commit:
  - commit_valid[1] = commit_en & alloc[head] & done[head].
  - commit_valid[0] = commit_valid[1] & alloc[head+1] & done[head+1]. Strictly in order; slot1 never retires without slot0.
  - At the edge, ncommit entries clear alloc/done and head += ncommit.
  - Latency: a completion in cycle N gives commit_valid in cycle N+1 at the earliest. Commit never uses same-cycle forwarding.
- Flush:
  - Priority over dispatch; dispatch is ignored in the flush cycle.
  - nsquash = (tail - flush_idx - 1) mod DEPTH. Those entries clear alloc/done; tail = flush_idx+1.
  - Completions targeting squashed entries that cycle are dropped.
  - Commit in the same cycle proceeds normally; committed entries are older than or equal to flush_idx.
  - flush_idx must be allocated. Otherwise behaviour is undefined, guarded by a simulation-only assertion.
- Count update: count_next = count + ndisp - ncommit - nsquash. Never exceeds 64 or drops below 0.
- disp_ready is computed from the registered count: (DEPTH - count) >= 4. Same-cycle commits do not free space for same-cycle dispatch.
- Wrap-around: all pointer arithmetic is mod DEPTH. full is distinguished from empty by count, not by pointer equality.

Test Plan:
- Reset, then dispatch 1111 for 16 cycles:
  - disp_idx_a steps 0,4,..,60.
  - After cycle 16: count=64, full=1, disp_ready=0.
  - A 17th request is dropped.
- Full ROB, complete idx 0 and 1 via fwd_a/fwd_b:
  - Next cycle: commit_valid=11, commit_idx0=0, commit_idx1=1.
  - Then head=2, count=62. disp_ready stays 0 until count<=60.
- Complete idx 1 only, with head=0:
  - commit_valid=00 (in order).
  - Then complete idx 0: next cycle commit_valid=11.
  - With commit_en=0: commit_valid=00 and head holds.
- Wrap: head=62, tail=62, dispatch 1111:
  - disp_idx = 62, 63, 0, 1; tail=2, count=4.
  - Complete all four: commits 62/63 then 0/1 over two cycles, head=2, empty=1.
- Flush: allocate 0..9, flush_idx=3 together with dispatch 1111:
  - tail=4, count=4, dispatch ignored.
  - A completion for idx 7 the following cycle is ignored.
- Assert rst_n=0 with count=20 and commit_valid=11 pending:
  - Outputs return to reset values immediately, count=0, no commit.
